// File: rtl/irq_timer_periph.sv
// Memory-mapped timer and interrupt controller.
// Provides a prescaled down-counter, six edge-detected external lines and a
// software-set bit, and combines them into a registered 8-bit irq vector.
// Register reads are combinational. Writes take effect on the clock edge.
module irq_timer_periph #(
  parameter int                   CPU_WIDTH   = 16,
  parameter logic [CPU_WIDTH-1:0] PERIPH_BASE = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] mem_addr,
  input  logic [CPU_WIDTH-1:0] mem_wd,
  input  logic                 mem_ctrl,
  output logic [CPU_WIDTH-1:0] mem_rd,
  output logic                 sel,
  input  logic [5:0]           ext_irq,
  output logic [7:0]           irq
);

  logic                 en_q,    en_d;
  logic                 auto_q,  auto_d;
  logic [3:0]           pre_q,   pre_d;
  logic [CPU_WIDTH-1:0] load_q,  load_d;
  logic [CPU_WIDTH-1:0] count_q, count_d;
  logic [7:0]           ie_q,    ie_d;
  logic [7:0]           ip_q,    ip_d;
  logic [3:0]           psc_q,   psc_d;
  logic [5:0]           ext_q,   ext_d;
  logic [7:0]           irq_q,   irq_d;

  logic [2:0] off;
  logic       wr_en;
  logic       ctrl_wr, load_wr, count_wr, ie_wr, ip_wr, ipset_wr;
  logic       tick, underflow;
  logic [5:0] rise;
  logic [7:0] hw_set, sw_set, clr;

  assign sel      = (mem_addr[CPU_WIDTH-1:3] == PERIPH_BASE[CPU_WIDTH-1:3]);
  assign off      = mem_addr[2:0];
  assign wr_en    = sel & mem_ctrl;
  assign ctrl_wr  = wr_en && (off == 3'd0);
  assign load_wr  = wr_en && (off == 3'd1);
  assign count_wr = wr_en && (off == 3'd2);
  assign ie_wr    = wr_en && (off == 3'd3);
  assign ip_wr    = wr_en && (off == 3'd4);
  assign ipset_wr = wr_en && (off == 3'd5);

  // The prescaler tick gates every timer step; an underflow is a tick at zero.
  assign tick      = en_q && (psc_q == pre_q);
  assign underflow = tick && (count_q == '0);
  assign rise      = ext_irq & ~ext_q;
  assign hw_set    = {1'b0, rise, underflow};
  assign sw_set    = ipset_wr ? mem_wd[7:0] : 8'h00;
  assign clr       = ip_wr    ? mem_wd[7:0] : 8'h00;
  assign irq       = irq_q;

  // Zero-latency read mux; unused offsets and misses return zero.
  always_comb begin
    mem_rd = '0;
    if (sel) begin
      unique case (off)
        3'd0:    mem_rd = CPU_WIDTH'({pre_q, 6'b0, auto_q, en_q});
        3'd1:    mem_rd = load_q;
        3'd2:    mem_rd = count_q;
        3'd3:    mem_rd = CPU_WIDTH'(ie_q);
        3'd4:    mem_rd = CPU_WIDTH'(ip_q);
        default: mem_rd = '0;
      endcase
    end
  end

  // Next-state logic: CPU writes take priority over hardware updates.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    pre_d   = pre_q;
    load_d  = load_q;
    count_d = count_q;
    ie_d    = ie_q;
    psc_d   = psc_q;

    // Prescaler: held at zero while disabled, restarted by any CTRL write.
    if (!en_q || ctrl_wr || tick) psc_d = 4'd0;
    else                          psc_d = psc_q + 4'd1;

    // Timer step; a one-shot underflow disables the timer.
    if (tick) begin
      if (count_q != '0)  count_d = count_q - 1'b1;
      else if (auto_q)    count_d = load_q;
      else                en_d    = 1'b0;
    end

    if (ctrl_wr) begin
      en_d   = mem_wd[0];
      auto_d = mem_wd[1];
      pre_d  = mem_wd[11:8];
    end
    if (load_wr)  load_d  = mem_wd;
    if (count_wr) count_d = mem_wd;
    if (ie_wr)    ie_d    = mem_wd[7:0];

    // Set wins over a simultaneous clear.
    ip_d  = (ip_q & ~clr) | hw_set | sw_set;
    ext_d = ext_irq;
    irq_d = ip_q & ie_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      pre_q   <= 4'd0;
      load_q  <= '0;
      count_q <= '0;
      ie_q    <= 8'h00;
      ip_q    <= 8'h00;
      psc_q   <= 4'd0;
      ext_q   <= 6'd0;
      irq_q   <= 8'h00;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      pre_q   <= pre_d;
      load_q  <= load_d;
      count_q <= count_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      psc_q   <= psc_d;
      ext_q   <= ext_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_irq_timer_periph.sv
// Directed bench for irq_timer_periph. Stimulus queues expected values;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_irq_timer_periph;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [15:0] mem_wd;
  logic        mem_ctrl;
  logic [15:0] mem_rd;
  logic        sel;
  logic [5:0]  ext_irq;
  logic [7:0]  irq;

  irq_timer_periph #(.CPU_WIDTH(16), .PERIPH_BASE(16'hFF00)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_ctrl (mem_ctrl),
    .mem_rd   (mem_rd),
    .sel      (sel),
    .ext_irq  (ext_irq),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = mem_rd, 1 = irq, 2 = sel
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  logic obs_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: when the stimulus flags an observation window, drain the queue.
  always @(negedge clk) begin
    if (obs_vld) begin
      while (q.size() > 0) begin
        exp_t        e;
        logic [15:0] act;
        e = q.pop_front();
        case (e.kind)
          0:       act = mem_rd;
          1:       act = {8'h00, irq};
          default: act = {15'h0, sel};
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    obs_vld = 1'b1;
    @(negedge clk);
    #1;
    obs_vld = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a;
    mem_wd   = d;
    mem_ctrl = 1'b1;
    step();
    mem_ctrl = 1'b0;
    mem_addr = 16'h0000;
    mem_wd   = 16'h0000;
  endtask

  task automatic exp_rd(input string n, input logic [15:0] a, input logic [15:0] v);
    exp_t e;
    mem_addr = a;
    mem_ctrl = 1'b0;
    e.kind = 0; e.name = n; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp_irq(input string n, input logic [7:0] v);
    exp_t e;
    e.kind = 1; e.name = n; e.exp = {8'h00, v};
    q.push_back(e);
  endtask

  task automatic exp_sel(input string n, input logic v);
    exp_t e;
    e.kind = 2; e.name = n; e.exp = {15'h0, v};
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; mem_addr = 16'h0; mem_wd = 16'h0; mem_ctrl = 1'b0; ext_irq = 6'h0;
    step(); step();
    rst = 1'b0;

    // Reset state: every slot reads zero, irq low, out-of-range miss.
    for (int i = 0; i < 8; i++) begin
      exp_rd($sformatf("reset_rd_%0d", i), 16'hFF00 + 16'(i), 16'h0000);
      if (i == 0) exp_irq("reset_irq", 8'h00);
      exp_sel($sformatf("reset_sel_%0d", i), 1'b1);
      obs(); step();
    end
    exp_rd("miss_rd", 16'hFF10, 16'h0000);
    exp_sel("miss_sel", 1'b0);
    obs(); step();

    // Auto-reload timer, PRE = 0, LOAD = 3.
    wr(16'hFF01, 16'd3);
    wr(16'hFF03, 16'h0001);
    wr(16'hFF00, 16'h0003);                 // E0
    exp_rd("auto_ip_e0", 16'hFF04, 16'h0000); exp_irq("auto_irq_e0", 8'h00); obs();
    step();                                  // E1: first underflow
    exp_rd("auto_ip_e1", 16'hFF04, 16'h0001); exp_irq("auto_irq_e1", 8'h00); obs();
    step();                                  // E2
    exp_rd("auto_cnt_e2", 16'hFF02, 16'd2);   exp_irq("auto_irq_e2", 8'h01); obs();
    wr(16'hFF04, 16'h0001);                 // E3: W1C
    exp_rd("auto_ip_w1c", 16'hFF04, 16'h0000); exp_irq("auto_irq_e3", 8'h01); obs();
    step();                                  // E4
    exp_rd("auto_cnt_e4", 16'hFF02, 16'd0);   exp_irq("auto_irq_fall", 8'h00); obs();
    step();                                  // E5: second underflow
    exp_rd("auto_ip_e5", 16'hFF04, 16'h0001); obs();
    step();                                  // E6
    exp_irq("auto_irq_e6", 8'h01); obs();
    step(); step();                          // E7, E8
    wr(16'hFF04, 16'h0001);                 // E9: clear collides with underflow
    exp_rd("collide_ip", 16'hFF04, 16'h0001); obs();
    wr(16'hFF05, 16'h0080);                 // E10
    exp_rd("ipset_ip", 16'hFF04, 16'h0081); obs();
    wr(16'hFF00, 16'h0000);
    wr(16'hFF04, 16'h00FF);
    wr(16'hFF03, 16'h0000);
    exp_rd("auto_ip_cleared", 16'hFF04, 16'h0000); obs();

    // One-shot with prescale: PRE = 2, COUNT = 2 -> underflow 9 edges later.
    wr(16'hFF01, 16'd2);
    wr(16'hFF02, 16'd2);
    wr(16'hFF00, 16'h0201);                 // F0
    for (int i = 0; i < 8; i++) step();      // F8
    exp_rd("oneshot_ip_f8", 16'hFF04, 16'h0000); obs();
    step();                                  // F9
    exp_rd("oneshot_ip_f9", 16'hFF04, 16'h0001); obs();
    step();
    exp_rd("oneshot_ctrl", 16'hFF00, 16'h0200); obs();
    step();
    exp_rd("oneshot_cnt", 16'hFF02, 16'h0000); obs();
    wr(16'hFF04, 16'h0001);
    for (int i = 0; i < 6; i++) step();
    exp_rd("oneshot_no_refire", 16'hFF04, 16'h0000); obs();

    // External edge on line 2 -> IP[3].
    wr(16'hFF03, 16'h00FE);
    ext_irq = 6'b000100;
    step();                                  // G1
    exp_rd("ext_ip_g1", 16'hFF04, 16'h0008); exp_irq("ext_irq_g1", 8'h00); obs();
    step();                                  // G2
    exp_irq("ext_irq_g2", 8'h08); obs();
    for (int i = 0; i < 7; i++) step();
    wr(16'hFF04, 16'h0008);
    step(); step();
    exp_rd("ext_held_once", 16'hFF04, 16'h0000); obs();
    ext_irq = 6'b000000;
    step(); step();
    wr(16'hFF03, 16'h00F6);
    ext_irq = 6'b000100;
    step();
    exp_rd("ext_masked_ip", 16'hFF04, 16'h0008); obs();
    step(); step();
    exp_irq("ext_masked_irq", 8'h00); obs();
    ext_irq = 6'b000000;
    step();

    // COUNT write against a tick, then reset mid-count.
    wr(16'hFF04, 16'h00FF);
    wr(16'hFF03, 16'h00FF);
    wr(16'hFF05, 16'h0080);
    wr(16'hFF02, 16'd5);
    wr(16'hFF00, 16'h0001);                 // H0
    step();                                  // H1
    wr(16'hFF02, 16'd100);                  // H2: write wins over tick
    exp_rd("cnt_wr_wins", 16'hFF02, 16'd100); exp_irq("pre_rst_irq", 8'h80); obs();
    step();
    exp_rd("cnt_after_wr", 16'hFF02, 16'd99); obs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd("rst_cnt", 16'hFF02, 16'h0000); exp_irq("rst_irq", 8'h00); obs();
    step();
    exp_rd("rst_ctrl", 16'hFF00, 16'h0000); obs();
    step();
    exp_rd("rst_ie", 16'hFF03, 16'h0000); obs();
    step();
    exp_rd("rst_ip", 16'hFF04, 16'h0000); obs();
    step();
    exp_rd("rst_load", 16'hFF01, 16'h0000); obs();
    step();

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
